// File: rtl/load_store_unit.sv
// Memory-access stage: runs one req/ack bus transaction per load/store, then
// aligns and extends load data and pulses the register-file write port.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_store_data,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        stall,
  output logic        access_fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic [1:0] {IDLE, BUS, WB} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [2:0]        funct3_reg, funct3_next;
  logic [1:0]        off_reg, off_next;
  logic [4:0]        rd_reg, rd_next;
  logic              is_store_reg, is_store_next;

  logic              mem_req_next, mem_we_next, reg_write_next, access_fault_next;
  logic [31:0]       mem_addr_next, mem_wdata_next, write_data_next;
  logic [3:0]        mem_wstrb_next;
  logic [4:0]        write_reg_next;
  logic [1:0]        fault_cause_next;

  logic              illegal, misaligned;
  logic [31:0]       st_wdata;
  logic [3:0]        st_wstrb;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_value;

  always_comb begin
    illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                 (req_is_store && req_funct3[2]);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Store lanes are replicated so the slave can pick any byte lane by strobe.
  always_comb begin
    st_wdata = req_store_data;
    st_wstrb = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        st_wdata = {4{req_store_data[7:0]}};
        st_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{req_store_data[15:0]}};
        st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[8*off_reg +: 8];
    ld_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_reg)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_value = {24'd0, ld_byte};
      3'b101:  ld_value = {16'd0, ld_half};
      default: ld_value = mem_rdata;
    endcase
  end

  assign req_ready = (state_reg == IDLE);
  assign stall     = (state_reg != IDLE) ||
                     (reset && req_valid && !illegal && !misaligned);

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    funct3_next       = funct3_reg;
    off_next          = off_reg;
    rd_next           = rd_reg;
    is_store_next     = is_store_reg;
    mem_req_next      = mem_req;
    mem_we_next       = mem_we;
    mem_addr_next     = mem_addr;
    mem_wdata_next    = mem_wdata;
    mem_wstrb_next    = mem_wstrb;
    reg_write_next    = 1'b0;
    write_reg_next    = write_reg;
    write_data_next   = write_data;
    access_fault_next = 1'b0;
    fault_cause_next  = fault_cause;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            access_fault_next = 1'b1;
            fault_cause_next  = 2'b10;
          end else if (misaligned) begin
            access_fault_next = 1'b1;
            fault_cause_next  = 2'b01;
          end else begin
            funct3_next    = req_funct3;
            off_next       = req_addr[1:0];
            rd_next        = req_rd;
            is_store_next  = req_is_store;
            cnt_next       = '0;
            mem_req_next   = 1'b1;
            mem_we_next    = req_is_store;
            mem_addr_next  = {req_addr[31:2], 2'b00};
            mem_wdata_next = req_is_store ? st_wdata : 32'd0;
            mem_wstrb_next = req_is_store ? st_wstrb : 4'b0000;
            state_next     = BUS;
          end
        end
      end
      BUS: begin
        // Ack is checked first so an ack on the final allowed cycle completes normally.
        if (mem_ack) begin
          mem_req_next   = 1'b0;
          mem_we_next    = 1'b0;
          mem_wstrb_next = 4'b0000;
          if (is_store_reg) begin
            state_next = IDLE;
          end else begin
            reg_write_next  = (rd_reg != 5'd0);
            write_reg_next  = rd_reg;
            write_data_next = ld_value;
            state_next      = WB;
          end
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          mem_req_next      = 1'b0;
          mem_we_next       = 1'b0;
          mem_wstrb_next    = 4'b0000;
          access_fault_next = 1'b1;
          fault_cause_next  = 2'b11;
          state_next        = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      funct3_reg   <= 3'd0;
      off_reg      <= 2'd0;
      rd_reg       <= 5'd0;
      is_store_reg <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      mem_wstrb    <= 4'd0;
      reg_write    <= 1'b0;
      write_reg    <= 5'd0;
      write_data   <= 32'd0;
      access_fault <= 1'b0;
      fault_cause  <= 2'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      funct3_reg   <= funct3_next;
      off_reg      <= off_next;
      rd_reg       <= rd_next;
      is_store_reg <= is_store_next;
      mem_req      <= mem_req_next;
      mem_we       <= mem_we_next;
      mem_addr     <= mem_addr_next;
      mem_wdata    <= mem_wdata_next;
      mem_wstrb    <= mem_wstrb_next;
      reg_write    <= reg_write_next;
      write_reg    <= write_reg_next;
      write_data   <= write_data_next;
      access_fault <= access_fault_next;
      fault_cause  <= fault_cause_next;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected bus requests,
// writebacks and faults; a monitor pops and compares as the DUT produces them.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_store_data = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'd0;
  logic [3:0]  mem_wstrb;
  logic        reg_write, stall, access_fault;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [1:0]  fault_cause;

  int checks = 0;
  int failures = 0;

  logic [68:0] bus_q[$];   // {we, addr, wdata, wstrb}
  logic [36:0] wb_q[$];    // {rd, data}
  int          fault_q[$];

  int          cur_delay = 1;
  logic [31:0] cur_rdata = 32'd0;
  int          bus_cnt = 0;
  bit          ack_done = 0;
  bit          prev_req = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_store_data(req_store_data),
    .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .stall(stall), .access_fault(access_fault), .fault_cause(fault_cause)
  );

  initial forever #5 clk = ~clk;

  // Bus slave: acks on the cur_delay-th cycle of a request; sprinkles stray acks while idle.
  initial forever begin
    @(negedge clk);
    if (mem_req) begin
      if (!ack_done) begin
        bus_cnt = bus_cnt + 1;
        if (bus_cnt == cur_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = cur_rdata;
          ack_done  = 1;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        mem_ack = 1'b0;
      end
    end else begin
      bus_cnt   = 0;
      ack_done  = 0;
      mem_ack   = ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic [68:0] eb;
    logic [36:0] ew;
    int ef;
    if (reset) begin
      if (mem_req && !prev_req) begin
        checks++;
        if (bus_q.size() == 0) begin
          failures++;
          $display("FAIL bus_req unexpected got addr=%h we=%b", mem_addr, mem_we);
        end else begin
          eb = bus_q.pop_front();
          if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== eb) begin
            failures++;
            $display("FAIL bus_req got we=%b addr=%h wdata=%h wstrb=%b exp %h",
                     mem_we, mem_addr, mem_wdata, mem_wstrb, eb);
          end
        end
      end
      if (reg_write) begin
        checks++;
        if (wb_q.size() == 0) begin
          failures++;
          $display("FAIL writeback unexpected got rd=%0d data=%h", write_reg, write_data);
        end else begin
          ew = wb_q.pop_front();
          if ({write_reg, write_data} !== ew) begin
            failures++;
            $display("FAIL writeback got rd=%0d data=%h exp rd=%0d data=%h",
                     write_reg, write_data, ew[36:32], ew[31:0]);
          end
        end
      end
      if (access_fault) begin
        checks++;
        if (fault_q.size() == 0) begin
          failures++;
          $display("FAIL fault unexpected got cause=%b", fault_cause);
        end else begin
          ef = fault_q.pop_front();
          if (fault_cause !== ef[1:0]) begin
            failures++;
            $display("FAIL fault_cause got %b exp %b", fault_cause, ef[1:0]);
          end
        end
      end
    end
    prev_req = mem_req;
  end

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    int v;
    case (f3)
      3'b000: begin v = int'((w >> (8 * off)) & 32'hFF);   if (v >= 128)   v -= 256;   end
      3'b001: begin v = int'((w >> (8 * (off & 2'd2))) & 32'hFFFF); if (v >= 32768) v -= 65536; end
      3'b100: v = int'((w >> (8 * off)) & 32'hFF);
      3'b101: v = int'((w >> (8 * (off & 2'd2))) & 32'hFFFF);
      default: v = int'(w);
    endcase
    return 32'(v);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd, output int issue_stall);
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = addr; req_store_data = data; req_rd = rd;
    #1 issue_stall = stall ? 1 : 0;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd, input int d,
                       input logic [31:0] rdata);
    bit   illegal, mis;
    int   n, exp_n, guard;
    logic [1:0]  off;
    logic [31:0] wd;
    logic [3:0]  ws;
    off     = addr[1:0];
    illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (st && (f3 == 4 || f3 == 5));
    mis     = ((f3 == 1 || f3 == 5) && off[0]) || (f3 == 2 && off != 0);
    exp_n   = 0;
    if (illegal) fault_q.push_back(2);
    else if (mis) fault_q.push_back(1);
    else begin
      wd = 32'd0; ws = 4'd0;
      if (st) begin
        if (f3 == 0)      begin wd = (data & 32'hFF) * 32'h0101_0101;  ws = 4'(1 << off); end
        else if (f3 == 1) begin wd = (data & 32'hFFFF) * 32'h0001_0001; ws = 4'(3 << (off & 2)); end
        else              begin wd = data; ws = 4'hF; end
      end
      bus_q.push_back({st, addr & 32'hFFFF_FFFC, wd, ws});
      if (d > TO) begin
        fault_q.push_back(3);
        exp_n = 1 + TO;
      end else if (st) begin
        exp_n = 1 + d;
      end else begin
        exp_n = 2 + d;
        if (rd != 0) wb_q.push_back({rd, load_model(f3, off, rdata)});
      end
    end
    cur_delay = d;
    cur_rdata = rdata;
    issue(st, f3, addr, data, rd, n);
    guard = 0;
    forever begin
      @(negedge clk);
      if (!stall || guard > 64) break;
      n++; guard++;
    end
    $display("op st=%0d f3=%0d addr=%h rd=%0d delay=%0d stall_cycles=%0d", st, f3, addr, rd, d, n);
    check("stall_cycles", 64'(n), 64'(exp_n));
  endtask

  initial begin
    int n, r, d;
    logic [2:0] f3;
    logic [2:0] f3_tab [0:11];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd6, 3'd7};

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, reg_write, write_reg,
           write_data, access_fault, fault_cause, stall}, 0);
    check("reset_ready", 64'(req_ready), 1);
    reset = 1'b1;

    do_op(0, 3'b010, 32'h100, 0, 5'd5, 1, 32'hDEAD_BEEF);
    do_op(0, 3'b000, 32'h103, 0, 5'd6, 1, 32'h80FF_1234);
    do_op(0, 3'b100, 32'h103, 0, 5'd7, 2, 32'h80FF_1234);
    do_op(0, 3'b101, 32'h102, 0, 5'd8, 1, 32'h80FF_1234);
    do_op(1, 3'b000, 32'h201, 32'h0000_00AB, 5'd9, 1, 32'd0);
    do_op(0, 3'b010, 32'h102, 0, 5'd3, 1, 32'd0);
    do_op(0, 3'b011, 32'h100, 0, 5'd3, 1, 32'd0);
    do_op(1, 3'b100, 32'h100, 0, 5'd3, 1, 32'd0);
    do_op(0, 3'b010, 32'h300, 0, 5'd4, TO + 1, 32'h1111_2222);
    do_op(0, 3'b010, 32'h304, 0, 5'd4, TO, 32'h3333_4444);
    do_op(0, 3'b001, 32'h306, 0, 5'd0, 2, 32'h8765_4321);

    // Reset in the middle of a bus transaction: the bus request must vanish at once.
    bus_q.push_back({1'b0, 32'h400, 32'd0, 4'd0});
    cur_delay = 100;
    issue(0, 3'b010, 32'h400, 0, 5'd10, n);
    repeat (4) @(negedge clk);
    check("mid_bus_req", 64'(mem_req), 1);
    #2 reset = 1'b0;
    #1;
    check("reset_drops_req", {mem_req, reg_write, req_ready}, 3'b001);
    @(negedge clk);
    #2 reset = 1'b1;
    do_op(0, 3'b010, 32'h500, 0, 5'd11, 1, 32'hCAFE_F00D);

    for (int i = 0; i < 150; i++) begin
      f3 = f3_tab[$urandom_range(0, 11)];
      r  = $urandom_range(0, 19);
      d  = (r < 16) ? 1 + (r % 4) : TO - 2 + (r - 16);
      do_op($urandom_range(0, 2) == 0, f3,
            32'h1000_0000 | ($urandom & 32'hFFFF), $urandom, 5'($urandom), d, $urandom);
    end

    repeat (4) @(negedge clk);
    check("bus_q_empty", 64'(bus_q.size()), 0);
    check("wb_q_empty", 64'(wb_q.size()), 0);
    check("fault_q_empty", 64'(fault_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
